// File: rtl/n2p_pkg.sv
// Shared definitions for the NOC-to-perm command path: word layout, default
// FIFO geometry and the per-cycle FIFO operation encoding.
package n2p_pkg;

  localparam int N2P_WIDTH = 17;
  localparam int N2P_DEPTH = 16;

  typedef struct packed {
    logic       ctl;
    logic [7:0] data;
    logic [7:0] dest;
  } n2p_word_t;

  // Accepted-operation encoding: bit 1 = write accepted, bit 0 = read accepted.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } n2p_op_e;

  function automatic n2p_op_e n2p_op(input logic wr_acc, input logic rd_acc);
    return n2p_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/n2p_fifo_mem.sv
// 1W/1R register array for the n2p FIFO; the read port is registered and
// resets to zero, the array itself is never cleared.
module n2p_fifo_mem #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-address write and read (full FIFO, simultaneous access) returns the
  // old word, which is the oldest entry being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/n2p_fifo_sync.sv
// Single-clock FIFO buffering NOC-to-perm command words, with occupancy count
// and sticky overflow/underflow indicators.
module n2p_fifo_sync
  import n2p_pkg::*;
#(
  parameter int WIDTH = N2P_WIDTH,
  parameter int DEPTH = N2P_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_acc;
  logic          wr_acc;
  n2p_op_e       op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A read on a full FIFO frees the slot the write needs in the same cycle.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    op     = n2p_op(wr_acc, rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (op)
        OP_WRITE: begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + CW'(1);
        end
        OP_READ: begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - CW'(1);
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + AW'(1);
          rd_ptr <= rd_ptr + AW'(1);
        end
        OP_IDLE: ;
      endcase
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

  n2p_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc && !rst),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_acc && !rst),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_n2p_fifo_sync.sv
// Directed bench for n2p_fifo_sync: a vector table for basic traffic plus
// hand-written sequences for fill/overflow, wrap under full load and reset.
module tb_n2p_fifo_sync;
  import n2p_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] data_in = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [16:0] data_out;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  n2p_fifo_sync #(
    .WIDTH(17),
    .DEPTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [16:0] din;
    logic [16:0] dout;
    logic        emp;
    logic        ful;
    logic [4:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic rd,
                              input logic [16:0] din, input logic [16:0] dout,
                              input logic emp, input logic ful, input logic [4:0] cnt,
                              input logic ovf, input logic unf);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.dout = dout;
    v.emp = emp; v.ful = ful; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [16:0] e_dout,
                           input logic e_emp, input logic e_ful, input logic [4:0] e_cnt,
                           input logic e_ovf, input logic e_unf);
    cmp(tag, "data_out",  32'(data_out),  32'(e_dout));
    cmp(tag, "empty",     32'(empty),     32'(e_emp));
    cmp(tag, "full",      32'(full),      32'(e_ful));
    cmp(tag, "count",     32'(count),     32'(e_cnt));
    cmp(tag, "overflow",  32'(overflow),  32'(e_ovf));
    cmp(tag, "underflow", 32'(underflow), 32'(e_unf));
  endtask

  // Drive inputs, let one rising edge pass, then settle 1 time unit.
  task automatic step(input logic r, input logic w, input logic rd, input logic [16:0] din);
    rst = r; wr_en = w; rd_en = rd; data_in = din;
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    n2p_word_t w0, w1, w2;
    logic [16:0] exp_d;
    w0 = '{ctl: 1'b1, data: 8'hA5, dest: 8'h03};
    w1 = '{ctl: 1'b0, data: 8'h3C, dest: 8'h03};
    w2 = '{ctl: 1'b0, data: 8'hFF, dest: 8'h03};

    //             rst   wr    rd    din        dout       emp   ful   cnt   ovf   unf
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 17'h0,     17'h0,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 17'h0,     17'h0,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, w0,        17'h0,     1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, w1,        17'h0,     1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, w2,        17'h0,     1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 17'h0,     17'h1A503, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 17'h0,     17'h03C03, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 17'h0,     17'h0FF03, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 17'h0,     17'h0FF03, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 17'h0,     17'h0FF03, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 17'h0,     17'h0,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    // read+write on empty: only the write lands, the read is an underflow
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 17'h12345, 17'h0,     1'b0, 1'b0, 5'd1, 1'b0, 1'b1);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 17'h0,     17'h12345, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 17'h0,     17'h0,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    #2;
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].emp, vecs[i].ful,
                vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to 16, drop a 17th write, then drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 17'(i));
    end
    check_all("fill16", 17'h0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 17'h1FFFF);
    check_all("wr17", 17'h0, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 17'h0);
      check_all($sformatf("drain%0d", i), 17'(i), (i == 15), 1'b0, 5'(15 - i), 1'b1, 1'b0);
    end

    // Full-load streaming across the pointer wrap.
    step(1'b1, 1'b0, 1'b0, 17'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 17'(100 + i));
    end
    check_all("refill", 17'h0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, 1'b1, 17'(200 + k));
      exp_d = (k < 16) ? 17'(100 + k) : 17'(200 + k - 16);
      check_all($sformatf("rw%0d", k), exp_d, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0);
    end
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 1'b0, 1'b1, 17'h0);
      check_all($sformatf("rwdrain%0d", j), 17'(204 + j), (j == 15), 1'b0,
                5'(15 - j), 1'b0, 1'b0);
    end

    // Reset with wr_en high discards stored words; no stale data afterwards.
    step(1'b1, 1'b0, 1'b0, 17'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 17'(17'h10000 + i));
    end
    check_all("pre_rst5", 17'h0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 17'h0AAAA);
    check_all("rst_wr", 17'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 17'h0);
    check_all("post_rst_rd", 17'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 17'h00ABC);
    step(1'b0, 1'b0, 1'b1, 17'h0);
    check_all("post_rst_wr_rd", 17'h00ABC, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
